// File: rtl/sbh_cg_controller.sv
// rtl/sbh_cg_controller.sv - sign-bit-hiding controller for one coefficient group
//
// Collects CG_SIZE coefficients, tracks the first/last nonzero positions,
// magnitude parity and leading sign, and keeps the cheapest legal +/-1
// magnitude adjustment. When the group qualifies for sign hiding and the
// parity disagrees with the leading sign, one update request is sent to the
// external coefficient-update datapath; the result is written back before
// the group is drained in scan order.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_coef       coefficient input stream (scan order)
//   in_cost_up/in_cost_down         rate-distortion cost of +1/-1 magnitude
//   upd_valid/upd_coef/upd_change   one-cycle update request
//   upd_min/upd_max                 signed clamp bounds for the datapath
//   upd_rvalid/upd_rcoef            update result
//   out_valid/out_ready/out_coef    coefficient output stream
//   out_last                        marks position CG_SIZE-1
//   sbh_applied                     pulse on the first drain cycle after a write-back
//   timeout_err                     sticky: update result never returned

module sbh_cg_controller #(
  parameter int COEFF_W    = 16,
  parameter int COST_W     = 16,
  parameter int CG_SIZE    = 16,
  parameter int SBH_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_coef,
  input  logic [COST_W-1:0]  in_cost_up,
  input  logic [COST_W-1:0]  in_cost_down,
  output logic               upd_valid,
  output logic [COEFF_W-1:0] upd_coef,
  output logic [1:0]         upd_change,
  output logic [COEFF_W:0]   upd_min,
  output logic [COEFF_W:0]   upd_max,
  input  logic               upd_rvalid,
  input  logic [COEFF_W-1:0] upd_rcoef,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_coef,
  output logic               out_last,
  output logic               sbh_applied,
  output logic               timeout_err
);

  localparam int IDX_W = (CG_SIZE > 1) ? $clog2(CG_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CG_SIZE - 1);
  localparam logic [IDX_W:0]   THRESH_V = (IDX_W + 1)'(SBH_THRESH);
  localparam logic [3:0]       WAIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_COLLECT, S_DECIDE, S_ISSUE, S_WAIT, S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [COEFF_W-1:0] buffer [CG_SIZE];
  logic [IDX_W-1:0]   idx, oidx;
  logic               nz_seen, parity, sign_neg;
  logic [IDX_W-1:0]   first_nz, last_nz;
  logic               best_valid, best_up;
  logic [IDX_W-1:0]   best_idx;
  logic [COST_W-1:0]  best_cost;
  logic [3:0]         wait_cnt;

  logic               beat, in_nz, in_one, at_first, down_legal;
  logic               up_take, down_take;
  logic [COST_W-1:0]  cost_after_up;
  logic [IDX_W:0]     span;
  logic               hide, mismatch;
  logic [COEFF_W-1:0] best_coef;
  logic               change_neg, drain_done, wait_timeout;

  // Candidate evaluation for the beat being accepted. "At firstNZ" is known
  // online: it is the first nonzero seen in this group.
  always_comb begin
    beat       = (state == S_COLLECT) && in_valid;
    in_nz      = |in_coef;
    in_one     = (in_coef == COEFF_W'(1)) || (in_coef == {COEFF_W{1'b1}});
    at_first   = in_nz && !nz_seen;
    down_legal = in_nz && !(at_first && in_one);
    // Up is considered first so that on equal cost at one position it wins.
    up_take       = !best_valid || (in_cost_up < best_cost);
    cost_after_up = up_take ? in_cost_up : best_cost;
    down_take     = down_legal && (in_cost_down < cost_after_up);
  end

  always_comb begin
    span     = {1'b0, last_nz} - {1'b0, first_nz};
    hide     = nz_seen && (span >= THRESH_V);
    mismatch = parity != sign_neg;
    best_coef = buffer[best_idx];
    // +1 magnitude moves away from zero; -1 magnitude moves toward zero.
    change_neg = best_up ? best_coef[COEFF_W-1]
                         : (|best_coef && !best_coef[COEFF_W-1]);
    drain_done   = (state == S_DRAIN) && out_ready && (oidx == LAST_IDX);
    wait_timeout = (state == S_WAIT) && !upd_rvalid && (wait_cnt == WAIT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_COLLECT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (in_valid && (idx == LAST_IDX)) state_nxt = S_DECIDE;
      S_DECIDE:  state_nxt = (hide && mismatch) ? S_ISSUE : S_DRAIN;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (upd_rvalid || wait_timeout) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_done) state_nxt = S_COLLECT;
      default:   state_nxt = S_COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state == S_COLLECT);
    upd_valid  = (state == S_ISSUE);
    upd_coef   = best_coef;
    upd_change = change_neg ? 2'b11 : 2'b01;
    upd_min    = {2'b11, {(COEFF_W-1){1'b0}}};
    upd_max    = {2'b00, {(COEFF_W-1){1'b1}}};
    out_valid  = (state == S_DRAIN);
    out_coef   = buffer[oidx];
    out_last   = (state == S_DRAIN) && (oidx == LAST_IDX);
  end

  // Coefficient storage is not reset; a reset abandons its contents.
  always_ff @(posedge clk) begin
    if (beat) begin
      buffer[idx] <= in_coef;
    end else if ((state == S_WAIT) && upd_rvalid) begin
      buffer[best_idx] <= upd_rcoef;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || drain_done) begin
      idx        <= '0;
      oidx       <= '0;
      nz_seen    <= 1'b0;
      parity     <= 1'b0;
      sign_neg   <= 1'b0;
      first_nz   <= '0;
      last_nz    <= '0;
      best_valid <= 1'b0;
      best_up    <= 1'b0;
      best_idx   <= '0;
      best_cost  <= '0;
      wait_cnt   <= '0;
      sbh_applied <= 1'b0;
      if (!rst_n) timeout_err <= 1'b0;
    end else begin
      sbh_applied <= (state == S_WAIT) && upd_rvalid;
      wait_cnt    <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (wait_timeout) timeout_err <= 1'b1;
      if (beat) begin
        idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        parity <= parity ^ in_coef[0];
        if (in_nz) begin
          last_nz <= idx;
          nz_seen <= 1'b1;
          if (!nz_seen) begin
            first_nz <= idx;
            sign_neg <= in_coef[COEFF_W-1];
          end
        end
        best_valid <= 1'b1;
        if (down_take) begin
          best_idx  <= idx;
          best_cost <= in_cost_down;
          best_up   <= 1'b0;
        end else if (up_take) begin
          best_idx  <= idx;
          best_cost <= in_cost_up;
          best_up   <= 1'b1;
        end
      end
      if ((state == S_DRAIN) && out_ready) oidx <= oidx + 1'b1;
    end
  end

endmodule

// File: tb/tb_sbh_cg_controller.sv
// tb/tb_sbh_cg_controller.sv - scoreboard bench for sbh_cg_controller

module tb_sbh_cg_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_coef;
  logic [15:0] in_cost_up;
  logic [15:0] in_cost_down;
  logic        upd_valid;
  logic [15:0] upd_coef;
  logic [1:0]  upd_change;
  logic [16:0] upd_min;
  logic [16:0] upd_max;
  logic        upd_rvalid;
  logic [15:0] upd_rcoef;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coef;
  logic        out_last;
  logic        sbh_applied;
  logic        timeout_err;

  sbh_cg_controller dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .in_cost_up(in_cost_up), .in_cost_down(in_cost_down),
    .upd_valid(upd_valid), .upd_coef(upd_coef), .upd_change(upd_change),
    .upd_min(upd_min), .upd_max(upd_max),
    .upd_rvalid(upd_rvalid), .upd_rcoef(upd_rcoef),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_last(out_last), .sbh_applied(sbh_applied), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] coef; logic last; } out_t;
  typedef struct { logic [15:0] coef; logic [1:0] chg; } upd_t;

  out_t exp_out_q[$];
  upd_t exp_upd_q[$];

  int checks = 0;
  int errors = 0;
  int out_seen = 0;
  int upd_seen = 0;
  int sbh_count = 0;
  int resp_mode = 1;      // 0: answer update requests, 1: stay silent
  logic [15:0] resp_val = '0;
  bit stray_req = 1'b0;

  logic [15:0] vec_c  [16];
  logic [15:0] vec_up [16];
  logic [15:0] vec_dn [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every DUT presentation against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_valid) begin
        upd_seen++;
        if (exp_upd_q.size() == 0) begin
          check("upd_unexpected", 32'd1, 32'd0);
        end else begin
          upd_t u;
          u = exp_upd_q.pop_front();
          check("upd_coef", 32'(upd_coef), 32'(u.coef));
          check("upd_change", 32'(upd_change), 32'(u.chg));
          check("upd_min", 32'(upd_min), 32'h18000);
          check("upd_max", 32'(upd_max), 32'h07fff);
        end
      end
      if (sbh_applied) begin
        sbh_count++;
        check("sbh_in_drain", 32'(out_valid), 32'd1);
      end
      if (out_valid) begin
        if (exp_out_q.size() == 0) begin
          check("out_unexpected", 32'd1, 32'd0);
        end else if (out_ready) begin
          out_t e;
          e = exp_out_q.pop_front();
          out_seen++;
          check("out_coef", 32'(out_coef), 32'(e.coef));
          check("out_last", 32'(out_last), 32'(e.last));
        end else begin
          check("stall_coef", 32'(out_coef), 32'(exp_out_q[0].coef));
          check("stall_last", 32'(out_last), 32'(exp_out_q[0].last));
        end
      end
    end
  end

  // Update-datapath responder, plus an optional stray result pulse.
  initial begin
    upd_rvalid = 1'b0;
    upd_rcoef  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && upd_valid && resp_mode == 0) begin
        repeat (3) @(posedge clk);
        #1 upd_rvalid = 1'b1; upd_rcoef = resp_val;
        @(posedge clk);
        #1 upd_rvalid = 1'b0;
      end else if (stray_req) begin
        @(posedge clk);
        #1 upd_rvalid = 1'b1; upd_rcoef = 16'd77;
        @(posedge clk);
        #1 upd_rvalid = 1'b0;
        stray_req = 1'b0;
      end
    end
  end

  task automatic fill(input logic [15:0] cu, input logic [15:0] cd);
    for (int i = 0; i < 16; i++) begin
      vec_c[i] = '0; vec_up[i] = cu; vec_dn[i] = cd;
    end
  endtask

  task automatic feed(input bit stray);
    for (int i = 0; i < 16; i++) begin
      int n;
      n = 0;
      in_valid = 1'b1; in_coef = vec_c[i];
      in_cost_up = vec_up[i]; in_cost_down = vec_dn[i];
      if (stray && i == 3) stray_req = 1'b1;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      check("in_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_cg(input string tag, input bit exp_issue, input logic [15:0] ucoef,
                        input logic [1:0] chg, input int pos, input logic [15:0] res,
                        input int mode, input bit stall, input bit stray, input bit exp_to);
    int n;
    int base;
    bit stalled;
    for (int i = 0; i < 16; i++) begin
      out_t e;
      e.coef = (exp_issue && mode == 0 && i == pos) ? res : vec_c[i];
      e.last = (i == 15);
      exp_out_q.push_back(e);
    end
    if (exp_issue) begin
      upd_t u;
      u.coef = ucoef; u.chg = chg;
      exp_upd_q.push_back(u);
    end
    resp_mode = mode; resp_val = res;
    sbh_count = 0;
    base = out_seen;
    stalled = 1'b0;
    feed(stray);
    n = 0;
    while ((exp_out_q.size() != 0 || exp_upd_q.size() != 0) && n < 500) begin
      if (stall && !stalled && out_seen - base == 5) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    check({tag, "_drained"}, 32'(n < 500), 32'd1);
    check({tag, "_out_count"}, 32'(out_seen - base), 32'd16);
    check({tag, "_sbh"}, 32'(sbh_count), 32'(exp_issue && mode == 0));
    check({tag, "_timeout"}, 32'(timeout_err), 32'(exp_to));
    exp_out_q.delete();
    exp_upd_q.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_coef = '0;
    in_cost_up = '0; in_cost_down = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_upd_valid", 32'(upd_valid), 32'd0);
    check("rst_sbh", 32'(sbh_applied), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // span 5, parity 0, sign positive: no change; stray result ignored
    fill(16'd10, 16'd10);
    vec_c[0] = 16'd3; vec_c[5] = 16'd1;
    run_cg("nohide", 0, '0, 2'b00, 0, '0, 0, 0, 1, 0);

    // same group with a 7-cycle stall mid-drain
    run_cg("stall", 0, '0, 2'b00, 0, '0, 0, 1, 0, 0);

    // parity 0, sign negative: cheapest is +1 at position 5 (2 -> 3)
    fill(16'd9, 16'd9);
    vec_c[0] = -16'sd2; vec_c[5] = 16'd2; vec_up[5] = 16'd4;
    run_cg("up5", 1, 16'd2, 2'b01, 5, 16'd3, 0, 0, 0, 0);

    // all costs equal: firstNZ wins with the up move (-2 -> -3)
    fill(16'd5, 16'd5);
    vec_c[0] = -16'sd2; vec_c[6] = 16'd4;
    run_cg("tie", 1, 16'hfffe, 2'b11, 0, 16'hfffd, 0, 0, 0, 0);

    // down at firstNZ with |coef|==1 is illegal; down at position 5 chosen (2 -> 1)
    fill(16'd8, 16'd1);
    vec_c[0] = 16'd1; vec_c[5] = 16'd2; vec_dn[5] = 16'd2;
    run_cg("down5", 1, 16'd2, 2'b11, 5, 16'd1, 0, 0, 0, 0);

    // result never returns: timeout, group drained unchanged
    fill(16'd9, 16'd9);
    vec_c[0] = -16'sd2; vec_c[5] = 16'd2; vec_up[5] = 16'd4;
    run_cg("tmo", 1, 16'd2, 2'b01, 5, 16'd3, 1, 0, 0, 1);

    // reset while waiting for the update result
    begin
      upd_t u;
      u.coef = 16'd2; u.chg = 2'b01;
      exp_upd_q.push_back(u);
    end
    resp_mode = 1;
    n = upd_seen;
    feed(0);
    begin
      int k;
      k = 0;
      while (upd_seen == n && k < 50) begin
        @(posedge clk); #1; k++;
      end
      check("rstwait_issue_seen", 32'(k < 50), 32'd1);
    end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rstwait_out_valid", 32'(out_valid), 32'd0);
    check("rstwait_in_ready", 32'(in_ready), 32'd1);
    check("rstwait_upd_valid", 32'(upd_valid), 32'd0);
    check("rstwait_timeout", 32'(timeout_err), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("rstwait_quiet", 32'(out_valid), 32'd0);
    check("rstwait_upd_q", 32'(exp_upd_q.size()), 32'd0);

    // next group after the reset processes normally
    fill(16'd5, 16'd5);
    vec_c[0] = -16'sd2; vec_c[6] = 16'd4;
    run_cg("after_rst", 1, 16'hfffe, 2'b11, 0, 16'hfffd, 0, 0, 0, 0);

    // all-zero group drains unchanged
    fill(16'd1, 16'd1);
    run_cg("zero", 0, '0, 2'b00, 0, '0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
